// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: matches the last cfg_len accepted bits
// against a loaded pattern, with optional overlap and a saturating match counter.
module seq_detect_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               dout,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0]   LEN_MIN = LEN_W'(2);
    localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   LEN_RST = LEN_W'(4);
    localparam logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(4'b1101);

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [MAX_LEN-1:0] history_q;
    logic [LEN_W-1:0]   fill_q;

    logic               accept;
    logic               cfg_ok;
    logic               match;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;

    always_comb begin
        accept    = din_valid && !cfg_we;
        cfg_ok    = (cfg_len >= LEN_MIN) && (cfg_len <= LEN_MAX);
        hist_next = {history_q[MAX_LEN-2:0], din};
        fill_inc  = (fill_q == LEN_MAX) ? fill_q : fill_q + 1'b1;
        len_mask  = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < 32'(len_q));
        end
        // Compare only the low len bits; the fill test uses the post-shift count.
        match = accept && (fill_inc >= len_q) &&
                (((hist_next ^ pattern_q) & len_mask) == '0);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pattern_q <= PAT_RST;
            len_q     <= LEN_RST;
            overlap_q <= 1'b1;
        end else if (cfg_we && cfg_ok) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
            overlap_q <= cfg_overlap;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            history_q <= '0;
            fill_q    <= '0;
        end else if (cfg_we) begin
            history_q <= '0;
            fill_q    <= '0;
        end else if (din_valid) begin
            history_q <= hist_next;
            fill_q    <= (match && !overlap_q) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dout        <= 1'b0;
            cfg_err     <= 1'b0;
            match_count <= '0;
        end else begin
            dout    <= match;
            cfg_err <= cfg_we && !cfg_ok;
            if (cnt_clr) begin
                match_count <= '0;
            end else if (match && (match_count != '1)) begin
                match_count <= match_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: bit-list reference model plus directed and random stimulus.
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               clr = 1'b1;
    logic               din_valid = 1'b0;
    logic               din = 1'b0;
    logic               cfg_we = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               dout, cfg_err, dout2, cfg_err2;
    logic [7:0]         match_count;
    logic [1:0]         match_count2;

    int n_cmp  = 0;
    int n_fail = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) dut (
        .clk(clk), .clr(clr), .din_valid(din_valid), .din(din), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .dout(dout), .match_count(match_count), .cfg_err(cfg_err)
    );

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) dut2 (
        .clk(clk), .clr(clr), .din_valid(din_valid), .din(din), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .dout(dout2), .match_count(match_count2), .cfg_err(cfg_err2)
    );

    // Reference model: a list of bits received since the last restart.
    bit   m_bits[$];
    int   m_len = 4;
    int   m_pat = 'hD;
    bit   m_ovl = 1'b1;
    bit   exp_dout = 1'b0;
    bit   exp_err = 1'b0;
    int   exp_cnt = 0;
    int   exp_cnt2 = 0;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_bits.delete();
            m_len = 4; m_pat = 'hD; m_ovl = 1'b1;
            exp_dout = 1'b0; exp_err = 1'b0; exp_cnt = 0; exp_cnt2 = 0;
        end else begin
            bit hit;
            hit = 1'b0;
            exp_err = 1'b0;
            if (cfg_we) begin
                if (cfg_len >= 2 && cfg_len <= MAX_LEN) begin
                    m_len = int'(cfg_len); m_pat = int'(cfg_pattern); m_ovl = cfg_overlap;
                end else begin
                    exp_err = 1'b1;
                end
                m_bits.delete();
            end else if (din_valid) begin
                m_bits.push_back(din);
                if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
                if (m_bits.size() >= m_len) begin
                    hit = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
                end
                if (hit && !m_ovl) m_bits.delete();
            end
            exp_dout = hit;
            if (cnt_clr) begin
                exp_cnt = 0; exp_cnt2 = 0;
            end else if (hit) begin
                if (exp_cnt < 255) exp_cnt++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: advance to the falling edge and compare the DUTs against the model.
    task automatic tick();
        @(negedge clk);
        check("dout", int'(dout), int'(exp_dout));
        check("cfg_err", int'(cfg_err), int'(exp_err));
        check("match_count", int'(match_count), exp_cnt);
        check("match_count_w2", int'(match_count2), exp_cnt2);
        if (dout) pulses++;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input bit b);
        din_valid = 1'b1; din = b; cfg_we = 1'b0;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send(bits[i]);
    endtask

    task automatic cfg(input logic [7:0] p, input int len, input bit ov);
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = LEN_W'(len); cfg_overlap = ov;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int p0, c0;
        tick(); tick();
        check("reset_count", int'(match_count), 0);
        check("reset_dout", int'(dout), 0);
        clr = 1'b0;

        // Default pattern 1101 with overlap
        p0 = pulses;
        send_seq(32'b1101101, 7);
        check("default_pulses", pulses - p0, 2);
        check("default_count", int'(match_count), 2);

        // 1111 without and with overlap on eight ones
        cfg(8'h0F, 4, 1'b0);
        c0 = int'(match_count);
        send_seq(32'hFF, 8);
        idle(1);
        check("no_overlap_count", int'(match_count) - c0, 2);
        cfg(8'h0F, 4, 1'b1);
        c0 = int'(match_count);
        send_seq(32'hFF, 8);
        idle(1);
        check("overlap_count", int'(match_count) - c0, 5);

        // A5 over an A5A5 stream with gaps between bits
        cfg(8'hA5, 8, 1'b1);
        p0 = pulses;
        for (int i = 15; i >= 0; i--) begin
            logic [15:0] s;
            s = 16'hA5A5;
            send(s[i]);
            idle($urandom_range(1, 3));
        end
        check("a5_pulses", pulses - p0, 2);

        // Rejected lengths keep the previous pattern
        cfg(8'hFF, 1, 1'b0);
        check("err_len1", int'(cfg_err), 1);
        idle(1);
        check("err_len1_clear", int'(cfg_err), 0);
        cfg(8'hFF, 9, 1'b0);
        check("err_len9", int'(cfg_err), 1);
        p0 = pulses;
        send_seq(32'hA5, 8);
        idle(1);
        check("old_pattern_pulses", pulses - p0, 1);

        // Narrow counter saturation, then clear racing a match
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        cfg(8'h0F, 4, 1'b1);
        send_seq(32'hFF, 8);
        check("w2_saturate", int'(match_count2), 3);
        din_valid = 1'b1; din = 1'b1; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0; din_valid = 1'b0;
        check("clr_vs_match_dout", int'(dout), 1);
        check("clr_vs_match_count", int'(match_count), 0);

        // Reset mid-sequence discards the partial history
        pulse_clr();
        p0 = pulses;
        send_seq(32'b110, 3);
        pulse_clr();
        send(1'b1);
        idle(2);
        check("clr_mid_pulses", pulses - p0, 0);
        send_seq(32'b1101, 4);
        check("after_clr_pulses", pulses - p0, 1);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            cnt_clr = ($urandom_range(0, 49) == 0);
            din_valid = ($urandom_range(0, 9) < 7);
            din = 1'($urandom);
            cfg_we = 1'b0;
            if (r < 4) begin
                cnt_clr = 1'b0;
                pulse_clr();
                continue;
            end else if (r < 30) begin
                cfg_we = 1'b1;
                cfg_pattern = 8'($urandom);
                cfg_len = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 15))
                                                      : LEN_W'($urandom_range(2, 4));
                cfg_overlap = 1'($urandom);
            end
            tick();
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8: maximum pattern length in bits; legal range 2..32.
REQ-002 SHALL have parameter LEN_W, default 4: width of cfg_len; SHALL be at least clog2(MAX_LEN+1).
REQ-003 SHALL have parameter CNT_W, default 8: width of match_count.
REQ-004 SHALL have input clk, 1 bit: clock; all state SHALL update on its rising edge.
REQ-005 SHALL have input clr, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have input din_valid, 1 bit: din is sampled on this edge.
REQ-007 SHALL have input din, 1 bit: serial data bit.
REQ-008 SHALL have input cfg_we, 1 bit: load the configuration inputs this cycle.
REQ-009 SHALL have input cfg_pattern, MAX_LEN bits: pattern, where bit [len-1] is the oldest bit and bit [0] is the newest.
REQ-010 SHALL have input cfg_len, LEN_W bits: pattern length.
REQ-011 SHALL have input cfg_overlap, 1 bit: 1 = overlapping matches allowed; 0 = history restarts after each match.
REQ-012 SHALL have input cnt_clr, 1 bit: synchronous clear of match_count.
REQ-013 SHALL have output dout, 1 bit: registered one-cycle match pulse.
REQ-014 SHALL have output match_count, CNT_W bits: saturating count of matches.
REQ-015 SHALL have output cfg_err, 1 bit: registered one-cycle pulse flagging a rejected configuration.

Function
REQ-016 SHALL keep a MAX_LEN-bit history shift register and a fill counter (0..MAX_LEN, saturating); each accepted bit shifts into history[0].
REQ-017 An accepted bit is one with din_valid=1 and cfg_we=0; when din_valid=0, history, fill and dout-generation SHALL hold.
REQ-018 A match SHALL be declared on an accepted bit when, after the shift, fill>=len and history[len-1:0]==pattern[len-1:0]; bits above len-1 SHALL be ignored.
REQ-019 dout SHALL be high for exactly the one cycle following the edge that accepted the matching bit, and low otherwise.
REQ-020 Overlap=1: history and fill SHALL be retained after a match, so pattern 1111 on input 11111 gives 2 matches.
REQ-021 Overlap=0: fill SHALL reset to 0 on the matching edge; the matching bit SHALL NOT count towards the next match.
REQ-022 On each match, match_count SHALL increment by 1 and saturate at 2^CNT_W-1.
REQ-023 When cnt_clr=1, match_count SHALL become 0 on that edge; cnt_clr SHALL take precedence over a simultaneous increment.
REQ-024 cfg_we with 2<=cfg_len<=MAX_LEN SHALL load pattern, len and overlap, and SHALL clear history and fill; match_count SHALL be kept.
REQ-025 cfg_we with cfg_len<2 or cfg_len>MAX_LEN SHALL leave the configuration unchanged, clear history and fill, and pulse cfg_err for one cycle.
REQ-026 cfg_we SHALL take precedence over din_valid in the same cycle: the bit is discarded and no match is declared.
REQ-027 The new configuration SHALL apply from the first accepted bit after the cfg_we edge.

Reset
REQ-028 While clr=1, the block SHALL force history=0, fill=0, dout=0, cfg_err=0 and match_count=0.
REQ-029 While clr=1, the block SHALL force pattern=4'b1101 (zero-extended), len=4 and overlap=1.
REQ-030 clr asserted mid-sequence SHALL discard partial history; detection SHALL restart from an empty history after release.
REQ-031 Inputs SHALL be ignored while clr=1; the first sampling edge SHALL be the first rising edge after clr deasserts.

Verification
REQ-032 After reset, din_valid=1 with bits 1,1,0,1,1,0,1 -> dout pulses after the 4th and 7th bits; match_count=2.
REQ-033 cfg_len=4, pattern 1111, overlap=0, bits 1×8 -> 2 matches; repeated with overlap=1 -> 5 matches.
REQ-034 cfg_len=8, pattern 8'hA5, stream 0xA5A5 (MSB first) with din_valid gaps of 1-3 cycles -> exactly 2 dout pulses, each one cycle after its completing bit.
REQ-035 cfg_len=1 or cfg_len=9 -> cfg_err=1 for one cycle; the previous pattern still detects correctly.
REQ-036 CNT_W=2 with 5 matches -> match_count=3; cnt_clr in the same cycle as a match -> match_count=0.
REQ-037 Bits 1,1,0 then clr pulse, then bit 1 -> no dout; a full 1,1,0,1 afterwards -> dout pulse.
